// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block controller.
// Round constants and initial hash values from FIPS 180-4.
package sha256_pkg;

  localparam int ROUNDS_DEF    = 64;
  localparam int MSG_WORDS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    EXPAND   = 3'd2,
    ROUNDS_S = 3'd3,
    UPDATE   = 3'd4,
    FIN      = 3'd5
  } state_e;

  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_of(input logic [5:0] idx);
    return K_TAB[idx];
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  round_i,
  output logic [31:0] k_o
);

  assign k_o = k_of(round_i);

endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 single-block sequencing FSM.
// Define SHA256_OVERLAP_EN to run expansion concurrently with rounds.
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS    = ROUNDS_DEF,
  parameter int MSG_WORDS = MSG_WORDS_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        FIRST_BLOCK,
  input  logic        ABORT,
  output logic [5:0]  CUR_MESSAGE_REG,
  output logic        CTRL_LOAD_REG,
  output logic [5:0]  ROUND,
  output logic        ROUND_EN,
  output logic [31:0] K_WORD,
  output logic        INIT_HASH,
  output logic        LOAD_WORKING,
  output logic        UPDATE_HASH,
  output logic        BUSY,
  output logic        DONE,
  output logic        DIGEST_VALID
);

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);
  localparam logic [5:0] MSG0 = 6'(MSG_WORDS);
`ifdef SHA256_OVERLAP_EN
  localparam logic [5:0] XP_SPAN = 6'(ROUNDS - MSG_WORDS);
`endif

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       dv_q, dv_d;
  logic [31:0] k_raw;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      dv_q    <= dv_d;
    end
  end

  // FIN ignores ABORT so a finished digest is never revoked.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    dv_d    = dv_q;
    if (ABORT && state_q != IDLE && state_q != FIN) begin
      state_d = IDLE;
      cnt_d   = '0;
      dv_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (START && !ABORT) begin
            state_d = LOAD;
            first_d = FIRST_BLOCK;
            dv_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        LOAD: begin
`ifdef SHA256_OVERLAP_EN
          state_d = ROUNDS_S;
          cnt_d   = '0;
`else
          state_d = EXPAND;
          cnt_d   = MSG0;
`endif
        end
        EXPAND: begin
          if (cnt_q == LAST) begin
            state_d = ROUNDS_S;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        ROUNDS_S: begin
          if (cnt_q == LAST) begin
            state_d = UPDATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        UPDATE: state_d = FIN;
        FIN: begin
          state_d = IDLE;
          dv_d    = 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign BUSY         = (state_q != IDLE);
  assign DONE         = (state_q == FIN);
  assign UPDATE_HASH  = (state_q == UPDATE);
  assign LOAD_WORKING = (state_q == LOAD);
  assign INIT_HASH    = (state_q == LOAD) && first_q;
  assign ROUND_EN     = (state_q == ROUNDS_S);
  assign ROUND        = ROUND_EN ? cnt_q : 6'd0;
  assign DIGEST_VALID = dv_q;

`ifdef SHA256_OVERLAP_EN
  assign CTRL_LOAD_REG   = ROUND_EN && (cnt_q < XP_SPAN);
  assign CUR_MESSAGE_REG = CTRL_LOAD_REG ? (cnt_q + MSG0) : 6'd0;
`else
  assign CTRL_LOAD_REG   = (state_q == EXPAND);
  assign CUR_MESSAGE_REG = CTRL_LOAD_REG ? cnt_q : 6'd0;
`endif

  sha256_k_rom u_k_rom (
    .round_i (ROUND),
    .k_o     (k_raw)
  );

  assign K_WORD = ROUND_EN ? k_raw : 32'd0;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Self-checking bench for sha256_block_ctrl (both build variants).
module tb_sha256_block_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        FIRST_BLOCK = 1'b0;
  logic        ABORT = 1'b0;
  logic [5:0]  CUR_MESSAGE_REG;
  logic        CTRL_LOAD_REG;
  logic [5:0]  ROUND;
  logic        ROUND_EN;
  logic [31:0] K_WORD;
  logic        INIT_HASH;
  logic        LOAD_WORKING;
  logic        UPDATE_HASH;
  logic        BUSY;
  logic        DONE;
  logic        DIGEST_VALID;

`ifdef SHA256_OVERLAP_EN
  localparam int R0_C = 2;
`else
  localparam int R0_C = 50;
`endif
  localparam int UPD_C = R0_C + 64;
  localparam int FIN_C = UPD_C + 1;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       upd;
    logic       lw;
    logic       ih;
    logic       ren;
    logic       cl;
    logic [5:0] cm;
    logic [5:0] rnd;
  } ctl_t;

  int n_chk = 0;
  int n_pass = 0;
  int cur_n = 0;
  int done_q[$];

  always #5 CLK = ~CLK;

  sha256_block_ctrl dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .START           (START),
    .FIRST_BLOCK     (FIRST_BLOCK),
    .ABORT           (ABORT),
    .CUR_MESSAGE_REG (CUR_MESSAGE_REG),
    .CTRL_LOAD_REG   (CTRL_LOAD_REG),
    .ROUND           (ROUND),
    .ROUND_EN        (ROUND_EN),
    .K_WORD          (K_WORD),
    .INIT_HASH       (INIT_HASH),
    .LOAD_WORKING    (LOAD_WORKING),
    .UPDATE_HASH     (UPDATE_HASH),
    .BUSY            (BUSY),
    .DONE            (DONE),
    .DIGEST_VALID    (DIGEST_VALID)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference timing; kill>=0 means the block dies after cycle kill.
  function automatic ctl_t model(input int n, input bit first,
                                 input int kill);
    ctl_t e;
    e = '0;
    if (kill >= 0 && n > kill) return e;
    if (n >= 1 && n <= FIN_C) e.busy = 1'b1;
    if (n == 1) begin
      e.lw = 1'b1;
      e.ih = first;
    end
    if (n >= 2 && n <= 49) begin
      e.cl = 1'b1;
      e.cm = 6'(n + 14);
    end
    if (n >= R0_C && n < R0_C + 64) begin
      e.ren = 1'b1;
      e.rnd = 6'(n - R0_C);
    end
    if (n == UPD_C) e.upd = 1'b1;
    if (n == FIN_C) e.done = 1'b1;
    return e;
  endfunction

  function automatic ctl_t obs();
    ctl_t o;
    o.busy = BUSY;
    o.done = DONE;
    o.upd  = UPDATE_HASH;
    o.lw   = LOAD_WORKING;
    o.ih   = INIT_HASH;
    o.ren  = ROUND_EN;
    o.cl   = CTRL_LOAD_REG;
    o.cm   = CUR_MESSAGE_REG;
    o.rnd  = ROUND;
    return o;
  endfunction

  // Scoreboard: every DONE pulse must match a queued expectation.
  always @(negedge CLK) begin
    if (DONE) begin
      if (done_q.size() == 0) check("done_spurious", 64'(cur_n), 64'(-1));
      else check("done_cycle", 64'(cur_n), 64'(done_q.pop_front()));
    end
  end

  task automatic run_blk(input string nm, input bit first,
                         input int abort_at, input int pulse_at,
                         input int reset_at);
    int kill;
    logic [63:0] exp_dv;
    kill = -1;
    if (abort_at >= 0 && abort_at < FIN_C) kill = abort_at;
    if (reset_at >= 0) kill = reset_at;
    @(negedge CLK);
    START = 1'b1;
    FIRST_BLOCK = first;
    if (kill < 0) done_q.push_back(FIN_C);
    @(posedge CLK);
    #1;
    START = 1'b0;
    FIRST_BLOCK = !first;
    for (int n = 1; n <= FIN_C + 1; n++) begin
      cur_n = n;
      check($sformatf("%s ctl c%0d", nm, n),
            64'(obs()), 64'(model(n, first, kill)));
      exp_dv = 64'((n == FIN_C + 1) && kill < 0);
      check($sformatf("%s dv c%0d", nm, n), 64'(DIGEST_VALID), exp_dv);
      if (kill < 0 && n == R0_C)
        check($sformatf("%s k0", nm), 64'(K_WORD), 64'h428a2f98);
      if (kill < 0 && n == R0_C + 63)
        check($sformatf("%s k63", nm), 64'(K_WORD), 64'hc67178f2);
      if (n == reset_at) begin
        #1 RESET = 1'b1;
        #1;
        check($sformatf("%s rst_ctl", nm), 64'(obs()), 64'd0);
        check($sformatf("%s rst_k", nm), 64'(K_WORD), 64'd0);
        check($sformatf("%s rst_dv", nm), 64'(DIGEST_VALID), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
      end
      START = (n == pulse_at);
      ABORT = (n == abort_at);
      @(posedge CLK);
      #1;
    end
    START = 1'b0;
    ABORT = 1'b0;
    FIRST_BLOCK = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("reset ctl", 64'(obs()), 64'd0);
    check("reset k", 64'(K_WORD), 64'd0);
    check("reset dv", 64'(DIGEST_VALID), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;

    run_blk("full", 1'b1, -1, -1, -1);

    @(negedge CLK);
    START = 1'b1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABORT = 1'b0;
    check("start+abort busy", 64'(BUSY), 64'd0);
    check("start+abort lw", 64'(LOAD_WORKING), 64'd0);

    run_blk("abort60", 1'b1, 60, -1, -1);
    run_blk("pulse30", 1'b1, -1, 30, -1);
    run_blk("abortfin", 1'b0, FIN_C, -1, -1);
    run_blk("reset20", 1'b1, -1, -1, 20);
    run_blk("second", 1'b0, -1, -1, -1);

    repeat (3) @(posedge CLK);
    #1;
    check("done_q drained", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
